// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that sequences four requesters onto a shared 4:1 mux.
// Optional hold limit forcing rotation is enabled by defining MUX_ARB_HOLD_LIMIT_EN.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic [3:0] GNT,
  output logic       S0,
  output logic       S1,
  output logic       VALID,
  output logic       Z
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_range
    $error("mux_rr_arbiter: HOLD_MAX must be within 1..15");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;

  logic       w_own_req;
  logic [3:0] w_others;
  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_hand;
  logic       w_preempt;

  // Index of the first set bit of req, searching upward from base+1 with wrap.
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      c = base + 2'(i) + 2'd1;
      if (req[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign w_own_req   = REQ[r_sel];
  assign w_others    = REQ & ~r_gnt;
  assign w_pick_idle = rr_pick(REQ, r_ptr);
  assign w_pick_hand = rr_pick(w_others, r_sel);

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam logic [3:0] L_CNT_LIM = 4'(HOLD_MAX - 1);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  assign w_preempt = (r_cnt >= L_CNT_LIM) && (|w_others);

  // Counter restarts on every new grant and saturates while nobody else waits.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt == GRANT) begin
      if ((r_state == IDLE) || (w_sel_nxt != r_sel)) begin
        w_cnt_nxt = 4'd0;
      end else if (r_cnt < L_CNT_LIM) begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end else begin
      w_cnt_nxt = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = onehot(w_pick_idle[1:0]);
          w_sel_nxt   = w_pick_idle[1:0];
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_pick_idle[1:0];
        end
      end
      GRANT: begin
        if (w_own_req && !w_preempt) begin
          w_state_nxt = GRANT;
        end else if (w_pick_hand[2]) begin
          // Direct handover keeps VALID high with no idle bubble.
          w_gnt_nxt   = onehot(w_pick_hand[1:0]);
          w_sel_nxt   = w_pick_hand[1:0];
          w_ptr_nxt   = w_pick_hand[1:0];
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 4'b0000;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_sel;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_valid <= 1'b0;
      r_ptr   <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign GNT   = r_gnt;
  assign S1    = r_sel[1];
  assign S0    = r_sel[0];
  assign VALID = r_valid;

  // Gated by VALID so a dropped grant can never leak a requester's data.
  always_comb begin
    Z = 1'b0;
    if (r_valid) begin
      unique case (r_sel)
        2'b00:   Z = A;
        2'b01:   Z = B;
        2'b10:   Z = C;
        2'b11:   Z = D;
        default: Z = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexer among four requesters (A, B, C, D).
- Registers the mux select lines S1/S0 and forwards the granted requester's data bit to Z.
- Sits in front of the existing 4:1 mux datapath as its sequencing controller.
- Select encoding follows the mux: {S1,S0} = 00→A, 01→B, 10→C, 11→D.

Parameters:
- HOLD_MAX, 4: max consecutive grant cycles for one owner while another requester waits. Used only with the optional feature. Legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- REQ  input  4  request; bit0=A, bit1=B, bit2=C, bit3=D
- A  input  1  data bit of requester 0
- B  input  1  data bit of requester 1
- C  input  1  data bit of requester 2
- D  input  1  data bit of requester 3
- GNT  output  4  one-hot registered grant, same bit order as REQ
- S0  output  1  registered select LSB
- S1  output  1  registered select MSB
- VALID  output  1  registered; high while any grant is active
- Z  output  1  muxed data of the owner when VALID=1, else 0 (combinational from S1/S0/VALID and A..D)

Behaviour:
- Reset (RST_N low, asynchronous): GNT=0000, S1=S0=0, VALID=0, Z=0, FSM=IDLE, last-owner pointer=3 (so the first search starts at A). Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- FSM states: IDLE, GRANT.
- IDLE:
  - REQ=0000: stay in IDLE.
  - Any REQ bit set: at the next edge, move to GRANT with the winner, where winner = first set REQ bit searching upward from pointer+1, wrapping 3→0.
  - Latency: REQ assertion to GNT/VALID high is exactly 1 cycle.
- GRANT, owner REQ still high:
  - Hold the grant. GNT, S1/S0 and the pointer are unchanged.
- GRANT, owner REQ low:
  - Another REQ bit set: at the next edge, hand over to the next winner, searching upward from owner+1. There is no idle gap, VALID stays 1 and the pointer updates to the new owner.
  - No other REQ bit set: at the next edge, return to IDLE. GNT=0000, VALID=0, S1/S0 keep their last value, pointer = last owner.
- Simultaneous requests are resolved strictly by rotation; there is no fixed priority beyond the search order.
- A REQ bit that drops before it is granted loses the request; nothing is queued.
- Invariants:
  - GNT is one-hot or zero.
  - GNT is nonzero iff VALID=1.
  - {S1,S0} equals the encoded GNT index whenever VALID=1.
- Z is never driven from a non-owner input.

Optional Feature:
- Macro: MUX_ARB_HOLD_LIMIT_EN.
- Defined:
  - A 4-bit hold counter clears on each new grant and increments every GRANT cycle.
  - When count reaches HOLD_MAX-1 and any other REQ bit is set, the grant is forcibly rotated at the next edge to the next requester after the owner, even if the owner's REQ is still high.
  - The preempted owner re-enters arbitration normally.
  - If no other requester is waiting, the counter saturates and the grant is held.
- Undefined:
  - No counter logic is present.
  - The owner holds the grant indefinitely while its REQ is high.
  - HOLD_MAX is ignored.

Test Plan:
- Reset, then REQ=0001, A=1: next cycle GNT=0001, S1S0=00, VALID=1, Z=1. Drop REQ: next cycle GNT=0000, VALID=0, Z=0.
- Pointer=3, REQ=1111 held, each owner drops its bit one cycle after being granted: grant order A→B→C→D, each 1 cycle apart, VALID continuously 1, S1S0 = 00, 01, 10, 11.
- Owner C granted, REQ changes to 1001: on C release, next grant is D (GNT=1000, S1S0=11), not A. After D releases, A is granted.
- RST_N pulled low for 3 ns mid-grant while D is owner: GNT=0000, VALID=0, Z=0 immediately, without a clock edge. After release with REQ=1000, D is granted 1 cycle after the first edge.
- MUX_ARB_HOLD_LIMIT_EN defined, HOLD_MAX=4, REQ=0011 held constant: A is granted for exactly 4 cycles, then B for 4, then A, repeating.
- MUX_ARB_HOLD_LIMIT_EN undefined, REQ=0011 held for 20 cycles: GNT stays 0001 throughout.
